daq_frame_reader: RTL and testbench
===================================

// Module: daq_frame_reader
// PURPOSE
//  Read side of the DAQ sample FIFO: drains 32-bit words, wraps them in byte frames, and streams
//  bytes to the UART TX over a valid/ready handshake. Frame = SYNC, SEQ, up to WORDS_PER_FRAME
//  words (MSB byte first), COUNT, optional CHK. Sits between the sample FIFO and the UART TX.
// PARAMETERS
//  DATA_WIDTH       32     FIFO word width; multiple of 8, 8..64
//  WORDS_PER_FRAME  4      max words per frame, 1..255
//  SYNC_BYTE        8'hA5  first byte of every frame
// PORTS
//  clk          in   1           clock
//  rst          in   1           reset, asynchronous, active-high
//  fifo_empty   in   1           FIFO empty flag
//  fifo_rd_en   out  1           FIFO read strobe (combinational from state)
//  fifo_data    in   DATA_WIDTH  FIFO registered output, valid the cycle after the rd_en edge
//  tx_data      out  8           byte to UART TX
//  tx_valid     out  1           tx_data valid
//  tx_ready     in   1           UART TX accepts byte
//  busy         out  1           high whenever state != IDLE
//  frames_sent  out  16          completed-frame counter, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE, tx_valid=0, tx_data=0, fifo_rd_en=0, seq=0, frames_sent=0, busy=0.
//  Byte transfer = tx_valid && tx_ready on a rising edge. tx_data/tx_valid are registered and stay
//   stable while tx_valid && !tx_ready. tx_valid never drops without a transfer.
//  FSM:
//   IDLE    if !fifo_empty: load SYNC_BYTE, tx_valid=1 -> SYNC; clear word_cnt and chk
//   SYNC    on transfer: present seq -> SEQ
//   SEQ     on transfer: chk^=seq, tx_valid=0 -> RD_REQ
//   RD_REQ  fifo_rd_en=1 if !fifo_empty -> LATCH; if fifo_empty: present word_cnt -> COUNT
//           The first RD_REQ of a frame always finds the FIFO non-empty; this block is the sole reader.
//   LATCH   capture fifo_data into shift reg, byte_idx=0, present MSB byte, tx_valid=1 -> BYTES
//   BYTES   on transfer: chk^=byte, shift left 8; on last byte word_cnt++, then
//           word_cnt==WORDS_PER_FRAME -> present word_cnt -> COUNT; else tx_valid=0 -> RD_REQ
//   COUNT   on transfer: chk^=count -> CHK (if enabled) else end-of-frame
//   CHK     on transfer: end-of-frame
//   end-of-frame: seq++ (mod 256), frames_sent++, tx_valid=0 -> IDLE
//  Latency: rd_en edge -> first byte of that word on tx_data at the 2nd following edge.
//  fifo_rd_en is high for exactly one cycle per word and never while fifo_empty.
//  Early end: FIFO empty at a word boundary closes the frame with the COUNT actually sent (>=1).
//  Data arriving during BYTES/COUNT does not reopen a closed frame; it starts the next frame.
//  Reset mid-frame: immediate return to reset values. The partial frame is dropped. A word already
//   popped is lost. The receiver resynchronises on SYNC_BYTE.
// CONFIGURATION
//  `DAQ_FRAME_CHECKSUM_EN defined: CHK byte = XOR of SEQ, all data bytes and COUNT, sent after COUNT.
//  Not defined: frame ends after COUNT. The chk register and CHK state are not built.
// STRUCTURE
//  Shared package daq_pkg: FSM state encoding localparams, default SYNC_BYTE, and
//   function bytes_per_word(DATA_WIDTH).
//  Sub-module daq_word_serializer: shift register, byte_idx, and tx_valid/tx_data handshake register.
//   Interface: load/word in; byte_done and last_byte out.
//  The FSM, counters and checksum stay in daq_frame_reader.
// TESTING
//  1. Preload 4 words 32'h11223344..; tx_ready=1 -> A5,00,11,22,33,44,...,04[,CHK]; frames_sent=1.
//  2. 1 word 32'hDEADBEEF -> A5,00,DE,AD,BE,EF,01[,CHK=00^DE^AD^BE^EF^01]; exactly one fifo_rd_en pulse.
//  3. 9 words, WORDS_PER_FRAME=4 -> frames of 4,4,1 words; SEQ bytes 00,01,02; frames_sent=3.
//  4. tx_ready random 30% -> identical byte sequence to test 1. tx_data never changes while
//     valid && !ready.
//  5. rst pulse during 2nd data byte -> outputs at reset values at once. Next frame SEQ=00 and
//     starts with A5.
//  6. Force 256 frames -> SEQ wraps FF->00. fifo_rd_en never high while fifo_empty (assertion).

Source files
------------

// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ frame reader: FSM state encoding,
// default sync byte and the word-to-byte sizing helper.
// The CHK state only exists when DAQ_FRAME_CHECKSUM_EN is defined.
package daq_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         STATE_W           = 3;
  // Wide enough for byte indices of words up to 64 bits
  localparam int         BYTE_IDX_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_SEQ    = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_LATCH  = 3'd4,
    ST_BYTES  = 3'd5,
    ST_COUNT  = 3'd6
`ifdef DAQ_FRAME_CHECKSUM_EN
    ,
    ST_CHK    = 3'd7
`endif
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/daq_word_serializer.sv
// Byte output stage of the frame reader. Holds the registered
// tx_data/tx_valid handshake pair and a shift register that walks a
// FIFO word out MSB byte first. Single header/trailer bytes are loaded
// directly through load_byte.
module daq_word_serializer
  import daq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  load_byte,
  input  logic [7:0]            byte_in,
  input  logic                  advance,
  input  logic                  clear,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  byte_done,
  output logic                  last_byte
);

  localparam int                    BPW      = bytes_per_word(DATA_WIDTH);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BPW - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BYTE_IDX_W-1:0] byte_idx;

  assign shift_next = shift_reg << 8;
  assign byte_done  = tx_valid && tx_ready;
  assign last_byte  = (byte_idx == LAST_IDX);

  // Handshake register: values only move on a control strobe, so the byte holds while unaccepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      byte_idx  <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= word;
      byte_idx  <= '0;
      tx_data   <= word[DATA_WIDTH-1 -: 8];
      tx_valid  <= 1'b1;
    end else if (load_byte) begin
      tx_data   <= byte_in;
      tx_valid  <= 1'b1;
    end else if (advance) begin
      shift_reg <= shift_next;
      byte_idx  <= byte_idx + BYTE_IDX_W'(1);
      tx_data   <= shift_next[DATA_WIDTH-1 -: 8];
    end else if (clear) begin
      tx_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/daq_frame_reader.sv
// Read side of the DAQ sample FIFO. Pops words and streams them to the
// UART TX as frames: SYNC, SEQ, data bytes (MSB first), COUNT and,
// when DAQ_FRAME_CHECKSUM_EN is defined, a trailing XOR checksum byte.
// A frame closes early when the FIFO runs dry at a word boundary.
module daq_frame_reader
  import daq_pkg::*;
#(
  parameter int         DATA_WIDTH      = 32,
  parameter int         WORDS_PER_FRAME = 4,
  parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam logic [7:0] WPF = 8'(WORDS_PER_FRAME);

  state_t     state;
  state_t     state_next;
  logic [7:0] seq;
  logic [7:0] word_cnt;
  logic [7:0] word_cnt_inc;

  logic       ser_load;
  logic       ser_load_byte;
  logic [7:0] ser_byte;
  logic       ser_advance;
  logic       ser_clear;
  logic       byte_done;
  logic       last_byte;

  logic       clr_frame;
  logic       word_inc;
  logic       frame_done;

`ifdef DAQ_FRAME_CHECKSUM_EN
  logic [7:0] chk;
  logic       chk_upd;
  logic [7:0] chk_in;
`endif

  assign word_cnt_inc = word_cnt + 8'd1;
  assign busy         = (state != ST_IDLE);

  daq_word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .word      (fifo_data),
    .load_byte (ser_load_byte),
    .byte_in   (ser_byte),
    .advance   (ser_advance),
    .clear     (ser_clear),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .byte_done (byte_done),
    .last_byte (last_byte)
  );

  // Frame sequencing: decides next state and strobes for the serializer and counters
  always_comb begin
    state_next    = state;
    fifo_rd_en    = 1'b0;
    ser_load      = 1'b0;
    ser_load_byte = 1'b0;
    ser_byte      = 8'h00;
    ser_advance   = 1'b0;
    ser_clear     = 1'b0;
    clr_frame     = 1'b0;
    word_inc      = 1'b0;
    frame_done    = 1'b0;
`ifdef DAQ_FRAME_CHECKSUM_EN
    chk_upd       = 1'b0;
    chk_in        = 8'h00;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          ser_load_byte = 1'b1;
          ser_byte      = SYNC_BYTE;
          clr_frame     = 1'b1;
          state_next    = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (byte_done) begin
          ser_load_byte = 1'b1;
          ser_byte      = seq;
          state_next    = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (byte_done) begin
`ifdef DAQ_FRAME_CHECKSUM_EN
          chk_upd    = 1'b1;
          chk_in     = seq;
`endif
          ser_clear  = 1'b1;
          state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_next = ST_LATCH;
        end else begin
          ser_load_byte = 1'b1;
          ser_byte      = word_cnt;
          state_next    = ST_COUNT;
        end
      end
      ST_LATCH: begin
        ser_load   = 1'b1;
        state_next = ST_BYTES;
      end
      ST_BYTES: begin
        if (byte_done) begin
`ifdef DAQ_FRAME_CHECKSUM_EN
          chk_upd = 1'b1;
          chk_in  = tx_data;
`endif
          if (last_byte) begin
            word_inc = 1'b1;
            if (word_cnt_inc == WPF) begin
              ser_load_byte = 1'b1;
              ser_byte      = word_cnt_inc;
              state_next    = ST_COUNT;
            end else begin
              ser_clear  = 1'b1;
              state_next = ST_RD_REQ;
            end
          end else begin
            ser_advance = 1'b1;
          end
        end
      end
      ST_COUNT: begin
        if (byte_done) begin
`ifdef DAQ_FRAME_CHECKSUM_EN
          chk_upd       = 1'b1;
          chk_in        = word_cnt;
          ser_load_byte = 1'b1;
          ser_byte      = chk ^ word_cnt;
          state_next    = ST_CHK;
`else
          frame_done = 1'b1;
          ser_clear  = 1'b1;
          state_next = ST_IDLE;
`endif
        end
      end
`ifdef DAQ_FRAME_CHECKSUM_EN
      ST_CHK: begin
        if (byte_done) begin
          frame_done = 1'b1;
          ser_clear  = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Per-frame word count plus sequence number and completed-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt    <= 8'h00;
      seq         <= 8'h00;
      frames_sent <= 16'h0000;
    end else begin
      if (clr_frame)     word_cnt <= 8'h00;
      else if (word_inc) word_cnt <= word_cnt_inc;
      if (frame_done) begin
        seq         <= seq + 8'd1;
        frames_sent <= frames_sent + 16'd1;
      end
    end
  end

`ifdef DAQ_FRAME_CHECKSUM_EN
  // Running XOR of every byte after SYNC, restarted when a frame opens
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            chk <= 8'h00;
    else if (clr_frame) chk <= 8'h00;
    else if (chk_upd)   chk <= chk ^ chk_in;
  end
`endif

endmodule

// File: tb/tb_daq_frame_reader.sv
// Self-checking bench for daq_frame_reader with a behavioural FIFO
// (registered output) and a byte capture queue on the TX side.
// Honours DAQ_FRAME_CHECKSUM_EN when building expected frames.
module tb_daq_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_data = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  int          push_count = 0;
  int          pop_count  = 0;
  logic [7:0]  cap_q [$];
  logic [7:0]  exp_q [$];
  int          rd_pulses     = 0;
  int          rd_empty_viol = 0;
  int          hold_viol     = 0;
  logic        hold          = 1'b0;
  logic [7:0]  hold_data     = 8'h00;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  seq;
    logic [7:0]  chk;
    logic [15:0] frames;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  assign fifo_empty = (push_count == pop_count);

  daq_frame_reader dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  // FIFO model with registered read data, plus TX byte capture
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      if (fifo_empty) begin
        rd_empty_viol++;
        $display("[TB] FAIL rd_en_while_empty: rd_en=1 empty=1 required rd_en=0 at %0t", $time);
      end else begin
        fifo_data <= mem[pop_count % 1024];
        pop_count <= pop_count + 1;
      end
    end
    if (tx_valid && tx_ready) cap_q.push_back(tx_data);
  end

  // A byte offered but not accepted must stay valid and unchanged next cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold && (!tx_valid || tx_data != hold_data)) begin
        hold_viol++;
        $display("[TB] FAIL tx_hold: valid=%0b data=%h required valid=1 data=%h", tx_valid, tx_data, hold_data);
      end
      hold      = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    mem[push_count % 1024] = w;
    push_count++;
  endtask

  task automatic wait_frames(input logic [15:0] target, input bit rnd, input string name);
    int n = 0;
    while (!(frames_sent == target && !busy) && n < 5000) begin
      @(negedge clk);
      if (rnd) tx_ready = ($urandom_range(0, 99) < 30);
      n++;
    end
    tx_ready = 1'b1;
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: frames_sent=%0d required %0d", name, frames_sent, target);
    end
  endtask

  task automatic add_frame(input logic [7:0] seq, input logic [31:0] words [$]);
    logic [7:0] c;
    c = seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    foreach (words[i]) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(words[i][b*8 +: 8]);
        c = c ^ words[i][b*8 +: 8];
      end
    end
    exp_q.push_back(8'(words.size()));
    c = c ^ 8'(words.size());
`ifdef DAQ_FRAME_CHECKSUM_EN
    exp_q.push_back(c);
`endif
  endtask

  task automatic compare_stream(input int base, input string name);
    checkOutput({name, "_len"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < cap_q.size())
        checkOutput($sformatf("%s_byte%0d", name, i), 32'(cap_q[base + i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    int          base;
    int          rd0;
    int          n;
    logic [7:0]  exp_seq;
    logic [15:0] exp_frames;
    logic [31:0] words [$];

    // hand-computed single-word frames (COUNT=01, CHK = seq^data bytes^01)
    vecs[0] = '{32'hDEADBEEF, 8'h00, 8'h23, 16'd1};
    vecs[1] = '{32'h00000000, 8'h01, 8'h00, 16'd2};
    vecs[2] = '{32'hFFFFFFFF, 8'h02, 8'h03, 16'd3};
    vecs[3] = '{32'h12345678, 8'h03, 8'h0A, 16'd4};

    rst      = 1'b1;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
    checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_frames", 32'(frames_sent), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table: single-word frames");
    for (int v = 0; v < 4; v++) begin
      base = cap_q.size();
      rd0  = rd_pulses;
      applyStimulus(vecs[v].word);
      wait_frames(vecs[v].frames, 1'b0, "table");
      exp_q.push_back(8'hA5);
      exp_q.push_back(vecs[v].seq);
      for (int b = 3; b >= 0; b--) exp_q.push_back(vecs[v].word[b*8 +: 8]);
      exp_q.push_back(8'h01);
`ifdef DAQ_FRAME_CHECKSUM_EN
      exp_q.push_back(vecs[v].chk);
`endif
      compare_stream(base, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_rd_pulses", v), 32'(rd_pulses - rd0), 32'd1);
      checkOutput($sformatf("vec%0d_frames", v), 32'(frames_sent), 32'(vecs[v].frames));
    end
    exp_seq    = 8'h04;
    exp_frames = 16'd4;

    $display("[TB] full frame of 4 words");
    base  = cap_q.size();
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    foreach (words[i]) applyStimulus(words[i]);
    add_frame(exp_seq, words);
    exp_seq++;
    exp_frames++;
    wait_frames(exp_frames, 1'b0, "full");
    compare_stream(base, "full");
    checkOutput("full_frames", 32'(frames_sent), 32'(exp_frames));

    $display("[TB] nine words split 4/4/1");
    base = cap_q.size();
    rd0  = rd_pulses;
    for (int i = 0; i < 9; i++) applyStimulus(32'hA0B0C0D0 + 32'(i));
    words = '{32'hA0B0C0D0, 32'hA0B0C0D1, 32'hA0B0C0D2, 32'hA0B0C0D3};
    add_frame(exp_seq, words);
    exp_seq++;
    words = '{32'hA0B0C0D4, 32'hA0B0C0D5, 32'hA0B0C0D6, 32'hA0B0C0D7};
    add_frame(exp_seq, words);
    exp_seq++;
    words = '{32'hA0B0C0D8};
    add_frame(exp_seq, words);
    exp_seq++;
    exp_frames = exp_frames + 16'd3;
    wait_frames(exp_frames, 1'b0, "split");
    compare_stream(base, "split");
    checkOutput("split_rd_pulses", 32'(rd_pulses - rd0), 32'd9);
    checkOutput("split_frames", 32'(frames_sent), 32'(exp_frames));

    $display("[TB] random backpressure");
    base  = cap_q.size();
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    foreach (words[i]) applyStimulus(words[i]);
    add_frame(exp_seq, words);
    exp_frames++;
    wait_frames(exp_frames, 1'b1, "backpressure");
    compare_stream(base, "backpressure");

    $display("[TB] reset during second data byte");
    base = cap_q.size();
    applyStimulus(32'hDEADBEEF);
    n = 0;
    while (cap_q.size() - base < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reach", 32'(cap_q.size() - base), 32'd3);
    tx_ready = 1'b0;
    @(negedge clk);
    checkOutput("midrst_hold_valid", 32'(tx_valid), 32'h1);
    checkOutput("midrst_hold_data", 32'(tx_data), 32'hAD);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("midrst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("midrst_rd_en", 32'(fifo_rd_en), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_frames", 32'(frames_sent), 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    base  = cap_q.size();
    words = '{32'hCAFEF00D};
    applyStimulus(words[0]);
    add_frame(8'h00, words);
    exp_frames = 16'd1;
    wait_frames(exp_frames, 1'b0, "after_rst");
    compare_stream(base, "after_rst");

    $display("[TB] sequence wrap over 256 frames");
    for (int i = 0; i < 256; i++) begin
      base = cap_q.size();
      applyStimulus({4{8'(i)}});
      exp_frames++;
      wait_frames(exp_frames, 1'b0, "wrap");
      exp_seq = 8'(i + 1);
      if (cap_q.size() > base + 1)
        checkOutput($sformatf("wrap_seq%0d", i), 32'(cap_q[base + 1]), 32'(exp_seq));
      else
        checkOutput($sformatf("wrap_len%0d", i), 32'(cap_q.size() - base), 32'd2);
    end
    checkOutput("wrap_frames", 32'(frames_sent), 32'd257);

    checkOutput("rd_en_never_empty", 32'(rd_empty_viol), 32'd0);
    checkOutput("tx_stable_hold", 32'(hold_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
